// File: rtl/huffman_symbol_fifo_if.sv
// Symbol stream bundle between the Huffman decoder, the symbol FIFO and its consumer.
// The slave modport is the FIFO's view. The master modport is the surrounding decoder/consumer view.
interface huffman_symbol_fifo_if #(
  parameter int SYM_W = 5
);
  logic [SYM_W-1:0] sym_in;
  logic             sym_valid;
  logic [SYM_W-1:0] m_symbol;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output sym_in, sym_valid, m_ready,
    input  m_symbol, m_valid
  );

  modport slave (
    input  sym_in, sym_valid, m_ready,
    output m_symbol, m_valid
  );
endinterface

// File: rtl/huffman_symbol_fifo.sv
// First-word fall-through elastic buffer for decoded Huffman symbols.
// It range-checks each symbol, flags drops and illegal values, and counts accepted symbols.
module huffman_symbol_fifo #(
  parameter int DEPTH   = 16,
  parameter int SYM_W   = 5,
  parameter int SYM_MIN = 1,
  parameter int SYM_MAX = 18,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  huffman_symbol_fifo_if.slave     bus,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     range_err,
  output logic [CNT_W-1:0]         sym_count,
  input  logic                     clear_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [SYM_W-1:0] L_MIN   = SYM_W'(SYM_MIN);
  localparam logic [SYM_W-1:0] L_MAX   = SYM_W'(SYM_MAX);
  localparam logic [LW-1:0]    L_DEPTH = LW'(DEPTH);

  logic [SYM_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow, r_range_err;
  logic [CNT_W-1:0] r_sym_count;

  logic w_in_range, w_legal, w_bad, w_pop, w_push, w_full, w_empty;

  always_comb begin
    w_full     = (r_level == L_DEPTH);
    w_empty    = (r_level == '0);
    w_in_range = (bus.sym_in >= L_MIN) && (bus.sym_in <= L_MAX);
    w_legal    = bus.sym_valid && w_in_range;
    w_bad      = bus.sym_valid && !w_in_range;
    w_pop      = !w_empty && bus.m_ready;
    // A pop in the same cycle frees the head slot, so a full buffer still accepts.
    w_push     = w_legal && (!w_full || w_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_range_err <= 1'b0;
      r_sym_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_push && (r_sym_count != '1)) r_sym_count <= r_sym_count + CNT_W'(1);
      // A new event in the same cycle as clear_err keeps the flag set.
      r_overflow  <= (r_overflow && !clear_err) || (w_legal && w_full && !w_pop);
      r_range_err <= (r_range_err && !clear_err) || w_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.sym_in;
  end

  always_comb begin
    bus.m_valid  = !w_empty;
    bus.m_symbol = w_empty ? '0 : r_mem[r_rd_ptr];
    full         = w_full;
    empty        = w_empty;
    level        = r_level;
    overflow     = r_overflow;
    range_err    = r_range_err;
    sym_count    = r_sym_count;
  end

  a_sym_range: assert property (@(posedge clk) disable iff (!rst)
    bus.m_valid |-> ((bus.m_symbol >= L_MIN) && (bus.m_symbol <= L_MAX)));
  a_level_max: assert property (@(posedge clk) disable iff (!rst) r_level <= L_DEPTH);
  a_full_empty: assert property (@(posedge clk) disable iff (!rst) !(w_full && w_empty));
endmodule

// File: tb/tb_huffman_symbol_fifo.sv
// Randomized bench for huffman_symbol_fifo against a queue-based reference model.
// A second instance with a 4-bit counter exercises sym_count saturation.
module tb_huffman_symbol_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  huffman_symbol_fifo_if #(.SYM_W(5)) bus ();
  logic       full, empty, overflow, range_err, clear_err;
  logic [4:0] level;
  logic [15:0] sym_count;

  huffman_symbol_fifo #(
    .DEPTH(16), .SYM_W(5), .SYM_MIN(1), .SYM_MAX(18), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .range_err(range_err), .sym_count(sym_count), .clear_err(clear_err)
  );

  huffman_symbol_fifo_if #(.SYM_W(5)) bus_b ();
  logic       full_b, empty_b, overflow_b, range_err_b;
  logic [4:0] level_b;
  logic [3:0] sym_count_b;

  huffman_symbol_fifo #(
    .DEPTH(16), .SYM_W(5), .SYM_MIN(1), .SYM_MAX(18), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .full(full_b), .empty(empty_b), .level(level_b),
    .overflow(overflow_b), .range_err(range_err_b), .sym_count(sym_count_b), .clear_err(1'b0)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] q[$];
  bit mdl_ovf, mdl_rerr;
  int mdl_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    q.delete();
    mdl_ovf  = 0;
    mdl_rerr = 0;
    mdl_cnt  = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_m_valid"},   bus.m_valid, 0);
    chk({tag, "_m_symbol"},  bus.m_symbol, 0);
    chk({tag, "_full"},      full, 0);
    chk({tag, "_empty"},     empty, 1);
    chk({tag, "_level"},     level, 0);
    chk({tag, "_overflow"},  overflow, 0);
    chk({tag, "_range_err"}, range_err, 0);
    chk({tag, "_sym_count"}, sym_count, 0);
  endtask

  task automatic chk_state();
    chk("level",     level, q.size());
    chk("empty",     empty, q.size() == 0);
    chk("full",      full, q.size() == 16);
    chk("m_valid",   bus.m_valid, q.size() != 0);
    if (q.size() != 0) chk("m_symbol", bus.m_symbol, q[0]);
    chk("overflow",  overflow, mdl_ovf);
    chk("range_err", range_err, mdl_rerr);
    chk("sym_count", sym_count, mdl_cnt);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, and checks the result.
  task automatic cyc(input bit v, input int s, input bit rdy, input bit clr);
    bit in_rng, legal, pop, was_full;
    bus.sym_valid = v;
    bus.sym_in    = 5'(s);
    bus.m_ready   = rdy;
    clear_err     = clr;
    in_rng   = (s >= 1) && (s <= 18);
    legal    = v && in_rng;
    pop      = (q.size() != 0) && rdy;
    was_full = (q.size() == 16);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (legal && (!was_full || pop)) begin
      q.push_back(5'(s));
      if (mdl_cnt < 65535) mdl_cnt++;
    end
    mdl_ovf  = (mdl_ovf && !clr) || (legal && was_full && !pop);
    mdl_rerr = (mdl_rerr && !clr) || (v && !in_rng);
    chk_state();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    bus.sym_valid = 0; bus.sym_in = '0; bus.m_ready = 0; clear_err = 0;
    bus_b.sym_valid = 0; bus_b.sym_in = '0; bus_b.m_ready = 1;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b1;

    // Fall-through latency with a consumer that is always ready
    cyc(1, 1, 1, 0);
    cyc(1, 5, 1, 0);
    cyc(1, 18, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t1_count", sym_count, 3);
    chk("t1_empty", empty, 1);

    // Fill, overflow, push-while-full-with-pop, then drain
    for (int i = 0; i < 16; i++) cyc(1, $urandom_range(1, 18), 0, 0);
    cyc(1, 7, 0, 0);
    chk("t2_overflow", overflow, 1);
    chk("t2_count", sym_count, 19);
    cyc(1, 9, 1, 0);
    chk("t2_level_swap", level, 16);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("t2_ovf_cleared", overflow, 0);

    // Illegal symbols and clear_err priority
    cyc(1, 0, 1, 0);
    cyc(1, 19, 1, 0);
    cyc(1, 31, 1, 0);
    chk("t3_rerr", range_err, 1);
    chk("t3_empty", empty, 1);
    cyc(0, 0, 1, 1);
    chk("t3_rerr_clr", range_err, 0);
    cyc(1, 25, 1, 1);
    chk("t3_rerr_setwins", range_err, 1);
    cyc(0, 0, 1, 1);

    // Random traffic across several pointer wraps, alternating congestion phases
    for (int i = 0; i < 400; i++) begin
      int s;
      bit v, rdy, clr;
      v   = ($urandom_range(0, 9) < 6);
      s   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 18));
      rdy = ((i / 50) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0);
      cyc(v, s, rdy, clr);
    end

    // Asynchronous reset mid-cycle with entries stored
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, $urandom_range(1, 18), 0, 0);
    chk("t5_level_pre", level, 5);
    bus.sym_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    chk_reset("arst");
    mdl_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 11, 0, 0);
    chk("t5_first_sym", bus.m_symbol, 11);
    cyc(0, 0, 1, 0);

    // Counter saturation on the 4-bit instance
    for (int n = 1; n <= 20; n++) begin
      bus_b.sym_valid = 1;
      bus_b.sym_in    = 5'($urandom_range(1, 18));
      @(posedge clk);
      #1;
      chk("sat_count", sym_count_b, (n < 15) ? n : 15);
    end
    bus_b.sym_valid = 0;
    @(posedge clk);
    #1;
    chk("sat_hold", sym_count_b, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/huffman_symbol_fifo.md
Name: huffman_symbol_fifo

Overview:
Elastic buffer directly downstream of the Huffman bit-serial decoder. It captures every decoded symbol (symbol_out/valid_out) in the cycle it is produced, range-checks it, and presents it to the consumer on a valid/ready stream. The decoder has no backpressure, so this block absorbs consumer stalls and flags lost or illegal symbols. It also keeps a saturating count of accepted symbols for status reads.

Parameters:
DEPTH, 16, entry count; power of two, >= 2
SYM_W, 5, symbol width
SYM_MIN, 1, lowest legal symbol value
SYM_MAX, 18, highest legal symbol value
CNT_W, 16, width of accepted-symbol counter

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert by the system
sym_in  input  SYM_W  decoded symbol from decoder symbol_out
sym_valid  input  1  decoder valid_out; qualifies sym_in for one cycle; no backpressure
m_symbol  output  SYM_W  head-of-queue symbol
m_valid  output  1  head entry valid
m_ready  input  1  consumer accepts head when m_valid && m_ready
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  $clog2(DEPTH)+1  stored entry count, 0..DEPTH
overflow  output  1  sticky: a legal symbol was dropped because the buffer was full
range_err  output  1  sticky: a symbol outside SYM_MIN..SYM_MAX arrived
sym_count  output  CNT_W  accepted symbols since reset; saturates at all-ones
clear_err  input  1  synchronous clear of overflow and range_err

Behaviour:
- Reset (rst = 0, asynchronous) forces:
  - m_valid=0, m_symbol=0, full=0, empty=1, level=0.
  - overflow=0, range_err=0, sym_count=0.
  - Read and write pointers = 0.
  - Storage contents are don't-care.
  - Reset asserted mid-stream discards all stored entries with no drain.
- Definitions:
  - legal = sym_valid && SYM_MIN <= sym_in <= SYM_MAX.
  - pop = m_valid && m_ready.
  - push = legal && (!full || pop).
- Range check:
  - sym_valid with an illegal value: symbol not stored, range_err set at the next edge, sym_count unchanged.
  - sym_in is ignored when sym_valid=0.
- Write:
  - push stores sym_in at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
  - legal && full && !pop: symbol dropped, overflow set, contents unchanged.
- Read:
  - First-word fall-through. m_valid = !empty. m_symbol = entry at rd_ptr.
  - pop advances rd_ptr modulo DEPTH.
  - m_symbol and m_valid hold stable while m_valid && !m_ready.
- Latency:
  - Symbol pushed at edge N appears on m_symbol/m_valid in the cycle after edge N, when the buffer was empty. No same-cycle combinational bypass from sym_in to m_symbol.
- Simultaneous push and pop:
  - level unchanged. Legal when full: the head leaves and the new symbol enters, no overflow.
  - When empty, pop is impossible (m_valid=0), so push alone occurs.
- Flags and counter:
  - level updates by +1 (push only), -1 (pop only), or 0 (both/neither). full and empty are derived from the registered level.
  - sym_count increments on each push and saturates at 2^CNT_W-1, never wrapping.
  - clear_err clears overflow and range_err at the next edge. If a new error event occurs in the same cycle as clear_err, the flag is set (set wins).
  - clear_err does not affect the buffer or sym_count.
- Assertions to include:
  - m_symbol within SYM_MIN..SYM_MAX whenever m_valid.
  - level <= DEPTH.
  - !(full && empty).

Test Plan:
- Reset then push symbols 1,5,18 on consecutive cycles with m_ready=1 -> m_symbol 1,5,18 each appears one cycle after its push; level never exceeds 1; sym_count=3; empty=1 at end.
- m_ready=0, push 16 legal symbols (DEPTH=16), then push 7 -> full=1 after the 16th push; 7 dropped; overflow=1; sym_count=16; draining yields the original 16 in order.
- Full buffer, m_ready=1, push 9 in the same cycle -> level stays 16, no overflow, 9 emerges last after the draining sequence.
- Push 0, then 19, then 31 -> none stored; range_err=1; empty=1; sym_count=0; pulse clear_err -> range_err=0. A coincident illegal symbol during clear_err leaves range_err=1.
- Random push/pop across 3 wraps of the pointers -> output order matches a reference queue; level is correct every cycle.
- Assert rst=0 asynchronously with 5 entries stored mid-clock -> outputs return to reset values immediately; after release, the first new push reads back correctly.
- Force sym_count near all-ones (CNT_W=4, 20 pushes) -> sym_count holds at 15.
